// File: rtl/m31_pkg.sv
// Shared M31 Poseidon2 types and constants: round-type encoding and standard round counts.
package m31_pkg;

  typedef enum logic [1:0] {
    RND_LIN  = 2'd0,
    RND_FULL = 2'd1,
    RND_PART = 2'd2
  } rnd_type_e;

  localparam int unsigned RF_P2    = 8;
  localparam int unsigned RP_P2_16 = 14;
  localparam int unsigned RP_P2_24 = 22;

  // Round j of the schedule: LIN first, then RF/2 full, RP partial, RF/2 full.
  function automatic rnd_type_e rnd_type_of(input int unsigned j, input int unsigned rf,
                                            input int unsigned rp);
    if (j == 0) return RND_LIN;
    if ((j > rf / 2) && (j <= rf / 2 + rp)) return RND_PART;
    return RND_FULL;
  endfunction

endpackage

// File: rtl/p2_round_ctrl.sv
// Poseidon2 round sequencer: walks the shared round datapath through load, LIN, full and
// partial rounds, owns round-constant addressing, and hands the result out via valid/ready.
module p2_round_ctrl
  import m31_pkg::*;
#(
  parameter int unsigned RF        = 8,
  parameter int unsigned RP        = 14,
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          start_valid,
  output logic                          start_ready,
  output logic                          dp_load,
  output logic                          dp_en,
  output rnd_type_e                     rnd_type,
  output logic [$clog2(RF+RP)-1:0]      rc_addr,
  output logic                          rnd_last,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned N        = 1 + RF + RP;
  localparam int unsigned RW       = $clog2(N + 1);
  localparam int unsigned AW       = $clog2(RF + RP);
  localparam int unsigned LW       = (ROUND_LAT > 2) ? $clog2(ROUND_LAT) : 1;
  localparam int unsigned LAT_INIT = (ROUND_LAT > 1) ? (ROUND_LAT - 2) : 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (((RF % 2) != 0) || (RF < 2) || (ROUND_LAT < 1)) begin : g_param_err
    $error("p2_round_ctrl: RF must be even and >= 2, ROUND_LAT must be >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [LW-1:0] lat_q, lat_d;

  logic          start_ready_q, start_ready_d;
  logic          dp_load_q, dp_load_d;
  logic          dp_en_q, dp_en_d;
  rnd_type_e     rnd_type_q, rnd_type_d;
  logic [AW-1:0] rc_addr_q, rc_addr_d;
  logic          rnd_last_q, rnd_last_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;

  // Next state; rnd_q counts issued rounds, so it reads N once the last one is out.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d = S_LOAD;
          rnd_d   = '0;
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        rnd_d = rnd_q + RW'(1);
        if (ROUND_LAT > 1) begin
          state_d = S_WAIT;
          lat_d   = LW'(LAT_INIT);
        end else if (rnd_q == RW'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = (rnd_q == RW'(N)) ? S_DONE : S_ISSUE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      rnd_d   = '0;
      lat_d   = '0;
    end
  end

  // Outputs are decoded from the next state so that every port comes straight off a flop.
  always_comb begin
    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    dp_load_d     = (state_d == S_LOAD);
    dp_en_d       = (state_d == S_ISSUE);
    out_valid_d   = (state_d == S_DONE);
    rnd_type_d    = RND_LIN;
    rc_addr_d     = '0;
    rnd_last_d    = 1'b0;
    if (state_d == S_ISSUE) begin
      rnd_type_d = rnd_type_of(32'(rnd_d), RF, RP);
      if (rnd_d != '0) rc_addr_d = AW'(rnd_d - RW'(1));
      rnd_last_d = (rnd_d == RW'(N - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rnd_q         <= '0;
      lat_q         <= '0;
      start_ready_q <= 1'b1;
      dp_load_q     <= 1'b0;
      dp_en_q       <= 1'b0;
      rnd_type_q    <= RND_LIN;
      rc_addr_q     <= '0;
      rnd_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rnd_q         <= rnd_d;
      lat_q         <= lat_d;
      start_ready_q <= start_ready_d;
      dp_load_q     <= dp_load_d;
      dp_en_q       <= dp_en_d;
      rnd_type_q    <= rnd_type_d;
      rc_addr_q     <= rc_addr_d;
      rnd_last_q    <= rnd_last_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign dp_load     = dp_load_q;
  assign dp_en       = dp_en_q;
  assign rnd_type    = rnd_type_q;
  assign rc_addr     = rc_addr_q;
  assign rnd_last    = rnd_last_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_p2_round_ctrl.sv
// Directed bench for p2_round_ctrl: default instance and an RP=22/ROUND_LAT=3 instance
// share stimulus; one is observed at a time through a packed output vector.
module tb_p2_round_ctrl;

  logic clk = 1'b0;
  logic rst, clr, start_valid, out_ready;
  logic sel;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       a_start_ready, a_dp_load, a_dp_en, a_rnd_last, a_busy, a_out_valid;
  logic [1:0] a_rnd_type;
  logic [4:0] a_rc_addr;
  logic       b_start_ready, b_dp_load, b_dp_en, b_rnd_last, b_busy, b_out_valid;
  logic [1:0] b_rnd_type;
  logic [4:0] b_rc_addr;

  // {dp_load, dp_en, rnd_type[1:0], rc_addr[4:0], rnd_last, out_valid, busy, start_ready}
  logic [12:0] obs_a, obs_b, obs;
  localparam logic [12:0] IDLE_V = 13'h0001;
  localparam logic [12:0] HOLD_V = 13'h0006;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  p2_round_ctrl u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .start_valid(start_valid), .start_ready(a_start_ready),
    .dp_load(a_dp_load), .dp_en(a_dp_en), .rnd_type(a_rnd_type), .rc_addr(a_rc_addr),
    .rnd_last(a_rnd_last), .busy(a_busy), .out_valid(a_out_valid), .out_ready(out_ready)
  );

  p2_round_ctrl #(.RF(8), .RP(22), .ROUND_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .start_valid(start_valid), .start_ready(b_start_ready),
    .dp_load(b_dp_load), .dp_en(b_dp_en), .rnd_type(b_rnd_type), .rc_addr(b_rc_addr),
    .rnd_last(b_rnd_last), .busy(b_busy), .out_valid(b_out_valid), .out_ready(out_ready)
  );

  assign obs_a = {a_dp_load, a_dp_en, a_rnd_type, a_rc_addr, a_rnd_last, a_out_valid, a_busy,
                  a_start_ready};
  assign obs_b = {b_dp_load, b_dp_en, b_rnd_type, b_rc_addr, b_rnd_last, b_out_valid, b_busy,
                  b_start_ready};
  assign obs   = sel ? obs_b : obs_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs t cycles after the accepting edge, RF fixed at 8.
  function automatic logic [12:0] exp_at(input int t, input int lat, input int rp);
    int n, tt, j;
    logic [12:0] v;
    n  = 9 + rp;
    tt = 2 + n * lat;
    v  = '0;
    if (t == 1) begin
      v[12] = 1'b1;
      v[1]  = 1'b1;
    end else if (t >= 2 && t < tt) begin
      v[1] = 1'b1;
      if (((t - 2) % lat) == 0) begin
        j     = (t - 2) / lat;
        v[11] = 1'b1;
        if (j == 0)           v[10:9] = 2'd0;
        else if (j <= 4)      v[10:9] = 2'd1;
        else if (j <= 4 + rp) v[10:9] = 2'd2;
        else                  v[10:9] = 2'd1;
        if (j > 0) v[8:4] = 5'(j - 1);
        v[3] = (j == n - 1);
      end
    end else if (t == tt) begin
      v[2] = 1'b1;
      v[1] = 1'b1;
    end
    return v;
  endfunction

  // Issue a request from a negedge and check every cycle up to stop_t (0 = whole run).
  task automatic run_perm(input int lat, input int rp, input bit hold_sv, input bit rdy,
                          input int stop_t, output int k);
    int  tt, lim;
    bit  seen;
    tt   = 2 + (9 + rp) * lat;
    lim  = (stop_t > 0) ? stop_t : tt;
    out_ready   = rdy;
    start_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (obs[0]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", 32'(seen), 32'd1);
    k = cyc + 1;
    for (int t = 1; t <= lim; t++) begin
      @(negedge clk);
      if (!hold_sv) start_valid = 1'b0;
      chk($sformatf("sched lat=%0d rp=%0d t=%0d", lat, rp, t), 32'(obs), 32'(exp_at(t, lat, rp)));
    end
    if (stop_t == 0 && rdy) begin
      @(negedge clk);
      chk("idle after run", 32'(obs), 32'(IDLE_V));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_valid = 1'b0;
    clr         = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k1, k2, k3;
    rst = 1'b1; clr = 1'b0; start_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset a", 32'(obs), 32'(IDLE_V));
    sel = 1'b1;
    #1;
    chk("reset b", 32'(obs), 32'(IDLE_V));
    sel = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;

    run_perm(1, 14, 1'b0, 1'b1, 0, k1);

    do_reset();
    run_perm(1, 14, 1'b1, 1'b1, 0, k1);
    run_perm(1, 14, 1'b1, 1'b1, 0, k2);
    run_perm(1, 14, 1'b1, 1'b1, 0, k3);
    start_valid = 1'b0;
    chk("b2b period 1", 32'(k2 - k1), 32'd26);
    chk("b2b period 2", 32'(k3 - k2), 32'd26);

    do_reset();
    sel = 1'b1;
    #1;
    run_perm(3, 22, 1'b0, 1'b1, 0, k1);
    sel = 1'b0;
    #1;

    do_reset();
    run_perm(1, 14, 1'b0, 1'b0, 0, k1);
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("backpressure hold %0d", i), 32'(obs), 32'(HOLD_V));
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    chk("backpressure release", 32'(obs), 32'(IDLE_V));

    do_reset();
    run_perm(1, 14, 1'b0, 1'b1, 12, k1);
    chk("clr point rc_addr", 32'(obs[8:4]), 32'd9);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr idle", 32'(obs), 32'(IDLE_V));
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("clr quiet %0d", i), 32'(obs), 32'(IDLE_V));
    end
    run_perm(1, 14, 1'b0, 1'b1, 0, k1);

    do_reset();
    run_perm(1, 14, 1'b0, 1'b1, 10, k1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset mid-PART", 32'(obs), 32'(IDLE_V));
    @(negedge clk);
    rst = 1'b0;
    run_perm(1, 14, 1'b0, 1'b1, 0, k1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
